// File: rtl/his_acq_scheduler_pkg.sv
// Shared types, default sizes and helpers for the SiFH acquisition scheduler.
package his_acq_scheduler_pkg;

   localparam int Np                = 10;
   localparam int PIXEL_NUM_PER_RAM = 3;
   localparam int ACQ_CYCLES_DEF    = 4;
   localparam int DRAIN_MAX_DEF     = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_SYNC = 3'd1,
      ST_COLLECT   = 3'd2,
      ST_DRAIN     = 3'd3,
      ST_READOUT   = 3'd4,
      ST_CLEAR     = 3'd5
   } acq_state_t;

   // Saturating 8-bit add for the drop counter.
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/his_acq_scheduler_if.sv
// Pixel-stream and histogram-builder handshake bundle for the acquisition scheduler.
interface his_acq_scheduler_if
   import his_acq_scheduler_pkg::*;
#(
   parameter int NP   = Np,
   parameter int NPIX = PIXEL_NUM_PER_RAM
) ();
   localparam int PIXW = (NPIX > 1) ? $clog2(NPIX) : 1;

   logic [NPIX-1:0]    pixValid;
   logic [NPIX*NP-1:0] pixData;
   logic [NPIX-1:0]    pixReady;
   logic               hbStall;
   logic               hbWrEn;
   logic [NP-1:0]      hbData;
   logic [PIXW-1:0]    hbPix;

   modport master (
      output pixValid, pixData, hbStall,
      input  pixReady, hbWrEn, hbData, hbPix
   );

   modport slave (
      input  pixValid, pixData, hbStall,
      output pixReady, hbWrEn, hbData, hbPix
   );
endinterface

// File: rtl/his_acq_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search begins one past the last granted index.
module rr_arbiter #(
   parameter  int N = 3,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         res,
   input  logic [N-1:0] req,
   input  logic         en,
   input  logic         adv,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx
);
   logic [W-1:0] ptr_r;
   logic [W-1:0] idx_s;
   logic         found_s;
   logic         hit_s;

   // First requester at or after the pointer, wrapping around.
   always_comb begin
      idx_s   = {W{1'b0}};
      found_s = 1'b0;
      hit_s   = 1'b0;
      for (int k = 0; k < N; k++) begin
         hit_s   = !found_s && req[(int'(ptr_r) + k) % N];
         idx_s   = hit_s ? W'((int'(ptr_r) + k) % N) : idx_s;
         found_s = found_s | hit_s;
      end
   end

   assign gnt = (en && found_s) ? (N'(1) << idx_s) : {N{1'b0}};
   assign idx = idx_s;

   // Pointer moves past the winner only when a transfer actually happens.
   always_ff @(posedge clk) begin
      if (res) begin
         ptr_r <= {W{1'b0}};
      end else if (adv) begin
         ptr_r <= (idx_s == W'(N - 1)) ? {W{1'b0}} : idx_s + {{(W-1){1'b0}}, 1'b1};
      end else begin
         ptr_r <= ptr_r;
      end
   end
endmodule

// File: rtl/his_acq_scheduler.sv
// Frames acquisitions in laser cycles, arbitrates pixel timestamps onto the
// histogram builder write port, then sequences readout and clear.
module his_acq_scheduler
   import his_acq_scheduler_pkg::*;
#(
   parameter int NP        = Np,
   parameter int NPIX      = PIXEL_NUM_PER_RAM,
   parameter int CYCLES    = ACQ_CYCLES_DEF,
   parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
   input  logic       clk,
   input  logic       res,
   input  logic       start,
   input  logic       contMode,
   input  logic       laserSync,
   his_acq_scheduler_if.slave bus,
   output logic       rdReq,
   input  logic       rdAck,
   output logic       clrHist,
   output logic       busy,
   output logic [7:0] dropCnt
);
   localparam int PIXW = (NPIX > 1) ? $clog2(NPIX) : 1;

   acq_state_t      state_r;
   logic [7:0]      cycle_cnt_r;
   logic [7:0]      drain_cnt_r;
   logic            arb_en_s;
   logic [NPIX-1:0] gnt_s;
   logic [PIXW-1:0] idx_s;
   logic            hs_s;
   logic            hb_wr_en_r;
   logic [NP-1:0]   hb_data_r;
   logic [PIXW-1:0] hb_pix_r;
   logic            rd_req_r;
   logic            clr_hist_r;
   logic            busy_r;
   logic [7:0]      drop_cnt_r;

   function automatic logic [7:0] popcnt(input logic [NPIX-1:0] v);
      logic [7:0] n;
      n = 8'd0;
      for (int k = 0; k < NPIX; k++) n = n + {7'd0, v[k]};
      return n;
   endfunction

   assign arb_en_s = ((state_r == ST_COLLECT) || (state_r == ST_DRAIN)) && !bus.hbStall;
   assign hs_s     = |gnt_s;

   rr_arbiter #(.N(NPIX)) u_arb (
      .clk (clk),
      .res (res),
      .req (bus.pixValid),
      .en  (arb_en_s),
      .adv (hs_s),
      .gnt (gnt_s),
      .idx (idx_s)
   );

   assign bus.pixReady = gnt_s;
   assign bus.hbWrEn   = hb_wr_en_r;
   assign bus.hbData   = hb_data_r;
   assign bus.hbPix    = hb_pix_r;
   assign rdReq        = rd_req_r;
   assign clrHist      = clr_hist_r;
   assign busy         = busy_r;
   assign dropCnt      = drop_cnt_r;

   // Builder write stage; data and index hold their last value between writes.
   always_ff @(posedge clk) begin
      if (res) begin
         hb_wr_en_r <= 1'b0;
         hb_data_r  <= {NP{1'b0}};
         hb_pix_r   <= {PIXW{1'b0}};
      end else if (hs_s) begin
         hb_wr_en_r <= 1'b1;
         hb_data_r  <= bus.pixData[int'(idx_s)*NP +: NP];
         hb_pix_r   <= idx_s;
      end else begin
         hb_wr_en_r <= 1'b0;
      end
   end

   // Acquisition sequencer; status outputs are updated together with the state.
   always_ff @(posedge clk) begin
      if (res) begin
         state_r     <= ST_IDLE;
         cycle_cnt_r <= 8'd0;
         drain_cnt_r <= 8'd0;
         rd_req_r    <= 1'b0;
         clr_hist_r  <= 1'b0;
         busy_r      <= 1'b0;
         drop_cnt_r  <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r <= ST_WAIT_SYNC;
                  busy_r  <= 1'b1;
               end
            end
            ST_WAIT_SYNC: begin
               if (laserSync) begin
                  state_r     <= ST_COLLECT;
                  cycle_cnt_r <= 8'd0;
               end
            end
            ST_COLLECT: begin
               if (laserSync) begin
                  cycle_cnt_r <= cycle_cnt_r + 8'd1;
                  if (cycle_cnt_r == 8'(CYCLES - 1)) begin
                     state_r     <= ST_DRAIN;
                     drain_cnt_r <= 8'd0;
                  end
               end
            end
            ST_DRAIN: begin
               if (bus.pixValid == {NPIX{1'b0}}) begin
                  state_r  <= ST_READOUT;
                  rd_req_r <= 1'b1;
               end else if (drain_cnt_r == 8'(DRAIN_MAX - 1)) begin
                  state_r    <= ST_READOUT;
                  rd_req_r   <= 1'b1;
                  drop_cnt_r <= sat_add8(drop_cnt_r, popcnt(bus.pixValid));
               end else begin
                  drain_cnt_r <= drain_cnt_r + 8'd1;
               end
            end
            ST_READOUT: begin
               if (rdAck) begin
                  state_r    <= ST_CLEAR;
                  rd_req_r   <= 1'b0;
                  clr_hist_r <= 1'b1;
               end
            end
            ST_CLEAR: begin
               clr_hist_r <= 1'b0;
               state_r    <= contMode ? ST_WAIT_SYNC : ST_IDLE;
               busy_r     <= contMode;
            end
            default: begin
               state_r    <= ST_IDLE;
               rd_req_r   <= 1'b0;
               clr_hist_r <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_his_acq_scheduler.sv
// Randomised and directed bench for his_acq_scheduler against a phase-level reference model.
module tb_his_acq_scheduler;
   localparam int NP        = 10;
   localparam int NPIX      = 3;
   localparam int CYCLES    = 4;
   localparam int DRAIN_MAX = 8;

   localparam int P_IDLE    = 0;
   localparam int P_WAIT    = 1;
   localparam int P_COLLECT = 2;
   localparam int P_DRAIN   = 3;
   localparam int P_READOUT = 4;
   localparam int P_CLEAR   = 5;

   logic       clk;
   logic       res;
   logic       start;
   logic       cont_mode;
   logic       laser_sync;
   logic       rd_ack;
   logic       rd_req;
   logic       clr_hist;
   logic       busy;
   logic [7:0] drop_cnt;

   his_acq_scheduler_if #(.NP(NP), .NPIX(NPIX)) bus ();

   his_acq_scheduler #(
      .NP(NP), .NPIX(NPIX), .CYCLES(CYCLES), .DRAIN_MAX(DRAIN_MAX)
   ) dut (
      .clk       (clk),
      .res       (res),
      .start     (start),
      .contMode  (cont_mode),
      .laserSync (laser_sync),
      .bus       (bus),
      .rdReq     (rd_req),
      .rdAck     (rd_ack),
      .clrHist   (clr_hist),
      .busy      (busy),
      .dropCnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int            m_phase;
   int            m_cycles;
   int            m_drain;
   int            m_last;
   int            m_drop;
   logic          m_wr;
   logic [NP-1:0] m_data;
   int            m_pix;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase  = P_IDLE;
      m_cycles = 0;
      m_drain  = 0;
      m_last   = NPIX - 1;
      m_drop   = 0;
      m_wr     = 1'b0;
      m_data   = '0;
      m_pix    = 0;
   endtask

   task automatic idle_inputs();
      start        = 1'b0;
      laser_sync   = 1'b0;
      rd_ack       = 1'b0;
      bus.pixValid = '0;
      bus.pixData  = '0;
      bus.hbStall  = 1'b0;
   endtask

   // Called at a falling edge with inputs applied: check outputs, advance the model, wait one cycle.
   task automatic step();
      int              g;
      int              c;
      int              pc;
      logic [NPIX-1:0] er;
      #1;
      g = -1;
      if ((m_phase == P_COLLECT || m_phase == P_DRAIN) && !bus.hbStall) begin
         for (int k = 1; k <= NPIX; k++) begin
            c = (m_last + k) % NPIX;
            if (g < 0 && bus.pixValid[c]) g = c;
         end
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("pixReady", bus.pixReady, er);
      chk("hbWrEn", bus.hbWrEn, m_wr);
      chk("hbData", bus.hbData, m_data);
      chk("hbPix", bus.hbPix, m_pix);
      chk("rdReq", rd_req, m_phase == P_READOUT);
      chk("clrHist", clr_hist, m_phase == P_CLEAR);
      chk("busy", busy, m_phase != P_IDLE);
      chk("dropCnt", drop_cnt, m_drop);
      if (res) begin
         model_reset();
      end else begin
         if (g >= 0) begin
            m_wr   = 1'b1;
            m_data = bus.pixData[g*NP +: NP];
            m_pix  = g;
            m_last = g;
         end else begin
            m_wr = 1'b0;
         end
         case (m_phase)
            P_IDLE:    if (start) m_phase = P_WAIT;
            P_WAIT:    if (laser_sync) begin m_phase = P_COLLECT; m_cycles = 0; end
            P_COLLECT: if (laser_sync) begin
                          m_cycles++;
                          if (m_cycles == CYCLES) begin m_phase = P_DRAIN; m_drain = 0; end
                       end
            P_DRAIN: begin
               pc = $countones(bus.pixValid);
               if (pc == 0) m_phase = P_READOUT;
               else begin
                  m_drain++;
                  if (m_drain == DRAIN_MAX) begin
                     m_phase = P_READOUT;
                     m_drop  = (m_drop + pc > 255) ? 255 : m_drop + pc;
                  end
               end
            end
            P_READOUT: if (rd_ack) m_phase = P_CLEAR;
            P_CLEAR:   m_phase = cont_mode ? P_WAIT : P_IDLE;
            default:   m_phase = P_IDLE;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic pulse_sync();
      laser_sync = 1'b1;
      step();
      laser_sync = 1'b0;
      step();
   endtask

   initial begin
      int guard;
      res       = 1'b1;
      cont_mode = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      model_reset();
      res = 1'b0;
      step();

      // Single pixel 0 with data 108.
      start = 1'b1; step(); start = 1'b0;
      laser_sync = 1'b1; step(); laser_sync = 1'b0;
      bus.pixValid = 3'b001;
      bus.pixData  = {10'd0, 10'd0, 10'd108};
      step();
      bus.pixValid = 3'b000;
      chk("single_wr", bus.hbWrEn, 1'b1);
      chk("single_data", bus.hbData, 10'd108);
      chk("single_pix", bus.hbPix, 2'd0);
      step();

      // All pixels valid: rotation continues after pixel 0.
      bus.pixValid = 3'b111;
      for (int k = 0; k < 9; k++) begin
         bus.pixData = 30'($urandom);
         step();
         chk("rotate_pix", bus.hbPix, 32'((1 + k) % NPIX));
      end

      // Stall for three cycles.
      bus.hbStall = 1'b1;
      repeat (3) step();
      chk("stall_nowr", bus.hbWrEn, 1'b0);
      bus.hbStall = 1'b0;
      repeat (4) step();

      // Four syncs into DRAIN, then pixel 1 held past the drain limit.
      bus.pixValid = 3'b010;
      repeat (CYCLES) pulse_sync();
      guard = 0;
      while (m_phase != P_READOUT && guard < 40) begin step(); guard++; end
      chk("drain_bound", guard < 40, 1'b1);
      bus.pixValid = 3'b000;
      chk("drop_one", drop_cnt, 8'd1);

      // rdAck arrives in the fifth readout cycle.
      repeat (4) begin chk("rdreq_hold", rd_req, 1'b1); step(); end
      rd_ack = 1'b1; step(); rd_ack = 1'b0;
      chk("clr_pulse", clr_hist, 1'b1);
      cont_mode = 1'b1;
      step();
      chk("clr_once", clr_hist, 1'b0);
      chk("cont_busy", busy, 1'b1);

      // Quick acquisition with nothing valid, ending in IDLE.
      pulse_sync();
      repeat (CYCLES) pulse_sync();
      step();
      rd_ack = 1'b1; step(); rd_ack = 1'b0;
      cont_mode = 1'b0;
      step();
      chk("idle_busy", busy, 1'b0);
      step();

      // Reset in the middle of a grant.
      start = 1'b1; step(); start = 1'b0;
      pulse_sync();
      bus.pixValid = 3'b111;
      bus.pixData  = 30'($urandom);
      step();
      res = 1'b1; step(); res = 1'b0;
      bus.pixValid = 3'b000;
      chk("rst_wr", bus.hbWrEn, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_data", bus.hbData, 10'd0);
      step();

      // Continuous acquisitions with all pixels valid to saturate the drop counter.
      cont_mode = 1'b1;
      rd_ack    = 1'b1;
      bus.pixValid = 3'b111;
      start = 1'b1; step(); start = 1'b0;
      for (int k = 0; k < 2500; k++) begin
         laser_sync  = k[0];
         bus.hbStall = ($urandom_range(0, 3) == 0);
         bus.pixData = 30'($urandom);
         step();
      end
      chk("drop_sat", drop_cnt, 8'd255);
      idle_inputs();
      cont_mode = 1'b0;

      // Fully random traffic.
      for (int k = 0; k < 4000; k++) begin
         res          = ($urandom_range(0, 299) == 0);
         start        = ($urandom_range(0, 9) == 0);
         cont_mode    = ($urandom_range(0, 3) != 0);
         laser_sync   = ($urandom_range(0, 5) == 0);
         rd_ack       = ($urandom_range(0, 3) == 0);
         bus.hbStall  = ($urandom_range(0, 4) == 0);
         bus.pixValid = 3'($urandom);
         bus.pixData  = 30'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
